// File: rtl/fft_inp_buf_pkg.sv
// ============================================================================
//  fft_inp_buf_pkg
//  Shared constants, bank state encoding and the 6-bit bit-reversal helper.
//  Rev 1.0
// ============================================================================
`default_nettype none

package fft_inp_buf_pkg;

    localparam int FFT_PTS      = 64;
    localparam int FFT_PTS_WD   = 6;
    localparam int FFT_PAIRS_WD = FFT_PTS_WD - 1;

    typedef logic [FFT_PTS_WD-1:0] wr_cnt_t;
    // One extra bit so "all 32 pairs issued" is distinguishable from pair 0
    typedef logic [FFT_PAIRS_WD:0] rd_cnt_t;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic logic [FFT_PTS_WD-1:0] bitrev6(input logic [FFT_PTS_WD-1:0] a);
        logic [FFT_PTS_WD-1:0] r;
        for (int i = 0; i < FFT_PTS_WD; i++) begin
            r[i] = a[FFT_PTS_WD-1-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_pp_bank.sv
// ============================================================================
//  fft_pp_bank
//  One 64-entry sample bank: single write port, two combinational read ports,
//  and its own EMPTY/FILLING/FULL/DRAINING occupancy state.
//  Rev 1.0
// ============================================================================
`default_nettype none

module fft_pp_bank
    import fft_inp_buf_pkg::*;
#(
    parameter int DATA_WD = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en_i,
    input  logic [FFT_PTS_WD-1:0] wr_addr_i,
    input  logic [DATA_WD-1:0]    wr_dat_i,
    input  logic                  rd_start_i,
    input  logic                  rd_done_i,
    input  logic [FFT_PTS_WD-1:0] rd_addr1_i,
    input  logic [FFT_PTS_WD-1:0] rd_addr2_i,
    output logic [DATA_WD-1:0]    rd_dat1_o,
    output logic [DATA_WD-1:0]    rd_dat2_o,
    output bank_state_e           state_o
);

    logic [DATA_WD-1:0] mem_q [FFT_PTS];
    bank_state_e        state_q;
    bank_state_e        state_d;
    logic               w_wr_last;

    // Sample storage needs no reset: the occupancy state gates every read
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BANK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_wr_last = wr_en_i && (wr_addr_i == FFT_PTS_WD'(FFT_PTS - 1));
        case (state_q)
            BANK_EMPTY:    if (wr_en_i)    state_d = w_wr_last ? BANK_FULL : BANK_FILLING;
            BANK_FILLING:  if (w_wr_last)  state_d = BANK_FULL;
            BANK_FULL:     if (rd_start_i) state_d = BANK_DRAINING;
            BANK_DRAINING: if (rd_done_i)  state_d = BANK_EMPTY;
            default:                       state_d = BANK_EMPTY;
        endcase
    end

    assign rd_dat1_o = mem_q[rd_addr1_i];
    assign rd_dat2_o = mem_q[rd_addr2_i];
    assign state_o   = state_q;

endmodule

`default_nettype wire

// File: rtl/fft_inp_buf.sv
// ============================================================================
//  fft_inp_buf
//  Ping-pong reorder buffer: natural-order samples in, bit-reversed DIT
//  first-stage pairs out, one frame per 64 cycles sustained.
//  Rev 1.0
// ============================================================================
`default_nettype none

module fft_inp_buf
    import fft_inp_buf_pkg::*;
#(
    parameter int DATA_INP_WD = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     inp_val_i,
    output logic                     inp_rdy_o,
    input  logic [2*DATA_INP_WD-1:0] inp_dat_i,
    output logic                     out_val_o,
    input  logic                     out_rdy_i,
    output logic [2*DATA_INP_WD-1:0] out_dat1_o,
    output logic [2*DATA_INP_WD-1:0] out_dat2_o,
    output logic [FFT_PAIRS_WD-1:0]  out_idx_o,
    output logic                     out_sop_o,
    output logic                     out_eop_o
);

    localparam int DW = 2 * DATA_INP_WD;

    logic                    rdy_en_q;
    logic                    wr_sel_q, wr_sel_d;
    wr_cnt_t                 wr_cnt_q, wr_cnt_d;
    logic                    rd_sel_q, rd_sel_d;
    rd_cnt_t                 rd_cnt_q, rd_cnt_d;
    logic                    out_val_q, out_val_d;
    logic [DW-1:0]           out_dat1_q, out_dat1_d;
    logic [DW-1:0]           out_dat2_q, out_dat2_d;
    logic [FFT_PAIRS_WD-1:0] out_idx_q, out_idx_d;
    logic                    out_sop_q, out_sop_d;
    logic                    out_eop_q, out_eop_d;

    bank_state_e             bank_st  [2];
    logic [DW-1:0]           bank_rd1 [2];
    logic [DW-1:0]           bank_rd2 [2];
    logic [1:0]              bank_wr_en, bank_rd_start, bank_rd_done;

    logic                    w_wr_acc, w_pair_done, w_src_sel, w_src_avail, w_rd_load, w_rd_start;
    rd_cnt_t                 w_src_cnt;
    bank_state_e             w_src_st;
    logic [FFT_PTS_WD-1:0]   w_rd_addr1, w_rd_addr2;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_pp_bank #(
            .DATA_WD (DW)
        ) u_bank (
            .clk        (clk),
            .rstn       (rstn),
            .wr_en_i    (bank_wr_en[g]),
            .wr_addr_i  (wr_cnt_q),
            .wr_dat_i   (inp_dat_i),
            .rd_start_i (bank_rd_start[g]),
            .rd_done_i  (bank_rd_done[g]),
            .rd_addr1_i (w_rd_addr1),
            .rd_addr2_i (w_rd_addr2),
            .rd_dat1_o  (bank_rd1[g]),
            .rd_dat2_o  (bank_rd2[g]),
            .state_o    (bank_st[g])
        );
    end

    always_comb begin
        inp_rdy_o  = rdy_en_q && ((bank_st[wr_sel_q] == BANK_EMPTY) ||
                                  (bank_st[wr_sel_q] == BANK_FILLING));
        w_wr_acc   = inp_val_i && inp_rdy_o;
        bank_wr_en = {w_wr_acc && wr_sel_q, w_wr_acc && !wr_sel_q};
        wr_cnt_d   = w_wr_acc ? wr_cnt_q + wr_cnt_t'(1) : wr_cnt_q;
        wr_sel_d   = (w_wr_acc && (&wr_cnt_q)) ? !wr_sel_q : wr_sel_q;

        // When the last pair leaves, the next load already comes from the other bank
        w_pair_done   = out_val_q && out_rdy_i && out_eop_q;
        w_src_sel     = rd_sel_q ^ w_pair_done;
        w_src_cnt     = w_pair_done ? rd_cnt_t'(0) : rd_cnt_q;
        w_src_st      = bank_st[w_src_sel];
        w_src_avail   = (w_src_st == BANK_FULL) ||
                        ((w_src_st == BANK_DRAINING) && !w_src_cnt[FFT_PAIRS_WD]);
        w_rd_load     = (!out_val_q || out_rdy_i) && w_src_avail;
        w_rd_start    = w_rd_load && (w_src_st == BANK_FULL);
        w_rd_addr1    = bitrev6({w_src_cnt[FFT_PAIRS_WD-1:0], 1'b0});
        w_rd_addr2    = {1'b1, w_rd_addr1[FFT_PTS_WD-2:0]};
        bank_rd_start = {w_rd_start && w_src_sel, w_rd_start && !w_src_sel};
        bank_rd_done  = {w_pair_done && rd_sel_q, w_pair_done && !rd_sel_q};
        rd_sel_d      = w_src_sel;
        rd_cnt_d      = w_rd_load ? w_src_cnt + rd_cnt_t'(1) : w_src_cnt;

        out_val_d  = out_val_q;
        out_dat1_d = out_dat1_q;
        out_dat2_d = out_dat2_q;
        out_idx_d  = out_idx_q;
        out_sop_d  = out_sop_q;
        out_eop_d  = out_eop_q;
        if (w_rd_load) begin
            out_val_d  = 1'b1;
            out_dat1_d = bank_rd1[w_src_sel];
            out_dat2_d = bank_rd2[w_src_sel];
            out_idx_d  = w_src_cnt[FFT_PAIRS_WD-1:0];
            out_sop_d  = (w_src_cnt[FFT_PAIRS_WD-1:0] == '0);
            out_eop_d  = &w_src_cnt[FFT_PAIRS_WD-1:0];
        end else if (out_rdy_i) begin
            out_val_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en_q   <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_cnt_q   <= '0;
            rd_sel_q   <= 1'b0;
            rd_cnt_q   <= '0;
            out_val_q  <= 1'b0;
            out_dat1_q <= '0;
            out_dat2_q <= '0;
            out_idx_q  <= '0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
        end else begin
            rdy_en_q   <= 1'b1;
            wr_sel_q   <= wr_sel_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_sel_q   <= rd_sel_d;
            rd_cnt_q   <= rd_cnt_d;
            out_val_q  <= out_val_d;
            out_dat1_q <= out_dat1_d;
            out_dat2_q <= out_dat2_d;
            out_idx_q  <= out_idx_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
        end
    end

    assign out_val_o  = out_val_q;
    assign out_dat1_o = out_dat1_q;
    assign out_dat2_o = out_dat2_q;
    assign out_idx_o  = out_idx_q;
    assign out_sop_o  = out_sop_q;
    assign out_eop_o  = out_eop_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_inp_buf.sv
// ============================================================================
//  tb_fft_inp_buf
//  Scoreboard bench: whole-frame reference model feeds an expected-pair queue.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fft_inp_buf;

    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [4:0]    idx;
        logic          sop;
        logic          eop;
    } pair_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          inp_val_i = 1'b0;
    logic          inp_rdy_o;
    logic [DW-1:0] inp_dat_i = '0;
    logic          out_val_o;
    logic          out_rdy_i = 1'b1;
    logic [DW-1:0] out_dat1_o, out_dat2_o;
    logic [4:0]    out_idx_o;
    logic          out_sop_o, out_eop_o;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            last_fill = 0;
    int            n_acc = 0;
    int            stall_cnt = 0;
    int            lat_checks = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: manual
    int            rdy_ph = 0;
    logic          chk_lat = 1'b0;
    logic [DW-1:0] fbuf[$];
    pair_t         exp_q[$];

    fft_inp_buf #(.DATA_INP_WD(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .inp_val_i  (inp_val_i),
        .inp_rdy_o  (inp_rdy_o),
        .inp_dat_i  (inp_dat_i),
        .out_val_o  (out_val_o),
        .out_rdy_i  (out_rdy_i),
        .out_dat1_o (out_dat1_o),
        .out_dat2_o (out_dat2_o),
        .out_idx_o  (out_idx_o),
        .out_sop_o  (out_sop_o),
        .out_eop_o  (out_eop_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int brev6(input int x);
        int r = 0;
        for (int i = 0; i < 6; i++) r |= ((x >> i) & 1) << (5 - i);
        return r;
    endfunction

    // Reference: once a frame of 64 accepted samples exists, list its 32 output pairs
    task automatic model_push(input logic [DW-1:0] d);
        pair_t e;
        fbuf.push_back(d);
        if (fbuf.size() == 64) begin
            for (int k = 0; k < 32; k++) begin
                e.d1  = fbuf[brev6(2 * k)];
                e.d2  = fbuf[brev6(2 * k + 1)];
                e.idx = 5'(k);
                e.sop = (k == 0);
                e.eop = (k == 31);
                exp_q.push_back(e);
            end
            fbuf.delete();
            last_fill = cyc + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rdy_mode == 0) begin
            out_rdy_i = 1'b1;
        end else if (rdy_mode == 1) begin
            out_rdy_i = (rdy_ph == 0 || rdy_ph == 3);
            rdy_ph    = (rdy_ph + 1) % 4;
        end
    endtask

    task automatic send_sample(input logic [DW-1:0] d);
        int t = 0;
        tick();
        inp_val_i = 1'b1;
        inp_dat_i = d;
        while (!inp_rdy_o && t < 5000) begin
            stall_cnt++;
            t++;
            tick();
        end
        if (!inp_rdy_o) begin
            chk("send_timeout", 0, 1);
        end else begin
            model_push(d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            inp_val_i = 1'b0;
        end
    endtask

    task automatic wait_empty(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            tick();
            inp_val_i = 1'b0;
            t++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        idle(3);
    endtask

    // Monitor: samples after the stimulus has settled, well before the next edge
    initial begin : monitor
        pair_t act, prev;
        logic  prev_stall = 1'b0;
        logic  prev_val   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                prev_stall = 1'b0;
                prev_val   = 1'b0;
            end else begin
                act = {out_dat1_o, out_dat2_o, out_idx_o, out_sop_o, out_eop_o};
                if (prev_stall) chk("stall_hold", {out_val_o, act}, {1'b1, prev});
                if (out_val_o && exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else if (out_val_o && out_rdy_i) begin
                    chk("pair", act, exp_q.pop_front());
                    n_acc++;
                end
                if (chk_lat && out_val_o && !prev_val) begin
                    chk("latency", cyc, last_fill + 1);
                    lat_checks++;
                end
                prev_stall = out_val_o && !out_rdy_i;
                prev_val   = out_val_o;
                prev       = act;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int t;
        repeat (3) @(negedge clk);
        chk("rst_inp_rdy", inp_rdy_o, 0);
        chk("rst_out", {out_val_o, out_dat1_o, out_dat2_o, out_idx_o, out_sop_o, out_eop_o}, 0);
        rstn = 1'b1;
        tick();
        chk("rdy_after_rst", inp_rdy_o, 1);

        // Single frame re=i, im=-i
        for (int i = 0; i < 64; i++) send_sample({16'(i), 16'(-i)});
        wait_empty(200);

        // Back-to-back random frames, continuous valid
        stall_cnt = 0;
        for (int i = 0; i < 256; i++) send_sample($urandom);
        wait_empty(400);
        chk("b2b_bubbles", (stall_cnt <= 4), 1);

        // Backpressure: both banks fill with no reads, then 1,0,0,1 drain
        rdy_mode  = 2;
        out_rdy_i = 1'b0;
        for (int i = 0; i < 128; i++) send_sample($urandom);
        tick();
        inp_val_i = 1'b1;
        chk("bp_wr_stall", inp_rdy_o, 0);
        rdy_mode = 1;
        rdy_ph   = 0;
        for (int i = 0; i < 128; i++) send_sample($urandom);
        wait_empty(5000);
        rdy_mode = 0;

        // Sparse input: one sample every third cycle
        chk_lat    = 1'b1;
        lat_checks = 0;
        for (int i = 0; i < 128; i++) begin
            send_sample($urandom);
            idle(2);
        end
        wait_empty(400);
        chk_lat = 1'b0;
        chk("lat_checks", lat_checks, 2);

        // Reset while frame 1 drains at k=10 and frame 2 holds 40 samples
        rdy_mode  = 2;
        out_rdy_i = 1'b0;
        for (int i = 0; i < 104; i++) send_sample($urandom);
        idle(1);
        out_rdy_i = 1'b1;
        base = n_acc;
        t    = 0;
        while (n_acc != base + 10 && t < 200) begin
            tick();
            t++;
        end
        out_rdy_i = 1'b0;
        chk("pre_rst_k10", {out_val_o, out_idx_o}, {1'b1, 5'd10});
        tick();
        rstn = 1'b0;
        fbuf.delete();
        exp_q.delete();
        #1;
        chk("midrst_out", {out_val_o, out_dat1_o, out_dat2_o, out_idx_o, out_sop_o, out_eop_o}, 0);
        chk("midrst_inp_rdy", inp_rdy_o, 0);
        idle(2);
        rstn     = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 64; i++) send_sample($urandom);
        wait_empty(200);

        chk("queue_drained", exp_q.size() + fbuf.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
